// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and filters encoder channels A/B and turns
// legal Gray-code steps into a wrapping up/down position count.
module quad_decoder #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o,
  output logic             dir_o,
  output logic             step_o,
  output logic             err_o
);

  localparam int INIT_LEN = FILTER_LEN + 2;
  localparam int ICW      = $clog2(INIT_LEN);
  localparam int FCW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic {
    S_INIT,
    S_TRACK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ICW-1:0]   r_init_cnt;
  logic             w_init_load;
  logic             w_track;

  // Channel bit 1 is A, bit 0 is B throughout.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       w_filt;
  logic [1:0]       r_prev;

  logic [1:0]       w_pos_prev;
  logic [1:0]       w_pos_cur;
  logic [1:0]       w_delta;
  logic             w_up;
  logic             w_dn;
  logic             w_bad;

  // Two-flop synchroniser per channel.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {quad_a, quad_b};
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel stability filter.
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic           r_filt;
    logic [FCW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_filt <= 1'b0;
        r_cnt  <= '0;
      end else if (w_init_load) begin
        r_filt <= r_sync2[g];
        r_cnt  <= '0;
      end else if (r_sync2[g] != r_filt) begin
        if (r_cnt == FCW'(FILTER_LEN - 1)) begin
          r_filt <= r_sync2[g];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + FCW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_filt[g] = r_filt;
  end

  // FSM: state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + ICW'(1);
      end else begin
        r_init_cnt <= '0;
      end
    end
  end

  // FSM: next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == ICW'(INIT_LEN - 1)) w_state_nxt = S_TRACK;
      S_TRACK: w_state_nxt = S_TRACK;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    w_init_load = 1'b0;
    w_track     = 1'b0;
    case (r_state)
      S_INIT:  w_init_load = 1'b1;
      S_TRACK: w_track     = 1'b1;
      default: w_init_load = 1'b1;
    endcase
  end

  // Previous filtered state; during INIT it follows the same source as the
  // filter so TRACK starts with prev == current and no spurious step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 2'b00;
    end else if (w_init_load) begin
      r_prev <= r_sync2;
    end else begin
      r_prev <= w_filt;
    end
  end

  // Map AB to a position on the up cycle 00,10,11,01 ({b, a^b}); the modulo-4
  // difference then reads 1 = up, 3 = down, 2 = double-edge.
  always_comb begin
    w_pos_prev = {r_prev[0], r_prev[1] ^ r_prev[0]};
    w_pos_cur  = {w_filt[0], w_filt[1] ^ w_filt[0]};
    w_delta    = w_pos_cur - w_pos_prev;
    w_up       = w_track && (w_delta == 2'd1);
    w_dn       = w_track && (w_delta == 2'd3);
    w_bad      = w_track && (w_delta == 2'd2);
  end

  // Position, direction, step strobe and sticky error; clear wins over a step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_o <= '0;
      dir_o   <= 1'b0;
      step_o  <= 1'b0;
      err_o   <= 1'b0;
    end else if (clear_i) begin
      count_o <= '0;
      step_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      step_o <= w_up | w_dn;
      if (w_up) begin
        count_o <= count_o + WIDTH'(1);
        dir_o   <= 1'b1;
      end else if (w_dn) begin
        count_o <= count_o - WIDTH'(1);
        dir_o   <= 1'b0;
      end
      if (w_bad) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8, FILTER_LEN=2); inputs change just
// after a falling edge and outputs are sampled on falling edges.
module tb_quad_decoder;

  logic       clock;
  logic       reset_n;
  logic       quad_a;
  logic       quad_b;
  logic       clear_i;
  logic [7:0] count_o;
  logic       dir_o;
  logic       step_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;

  quad_decoder #(.WIDTH(8), .FILTER_LEN(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
    .clear_i (clear_i),
    .count_o (count_o),
    .dir_o   (dir_o),
    .step_o  (step_o),
    .err_o   (err_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset(input logic a, input logic b);
    reset_n = 1'b0;
    quad_a  = a;
    quad_b  = b;
    clear_i = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Move inputs to a new AB value and let the step fully settle.
  task automatic step_to(input logic a, input logic b);
    quad_a = a;
    quad_b = b;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset;
    int pulses;
    reset_n = 1'b0;
    quad_a  = 1'b1;
    quad_b  = 1'b1;
    clear_i = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({count_o, dir_o, step_o, err_o} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_values: got count=%0d dir=%0b step=%0b err=%0b, want all 0",
               count_o, dir_o, step_o, err_o);
    end
    reset_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (step_o === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_no_step: got %0d step pulses, want 0", pulses);
    end
    n_checks++;
    if (count_o !== 8'd0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_init: got count=%0d err=%0b, want count=0 err=0", count_o, err_o);
    end
  endtask

  task automatic test_up_cycle;
    logic [1:0] seq [4];
    seq[0] = 2'b10;
    seq[1] = 2'b11;
    seq[2] = 2'b01;
    seq[3] = 2'b00;
    do_reset(1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      quad_a = seq[s][1];
      quad_b = seq[s][0];
      for (int k = 1; k <= 8; k++) begin
        @(negedge clock);
        n_checks++;
        if (step_o !== (k == 5)) begin
          n_fail++;
          $display("FAIL up_step_timing: step %0d cycle %0d got step=%0b, want %0b",
                   s, k, step_o, (k == 5));
        end
      end
    end
    n_checks++;
    if (count_o !== 8'd4 || dir_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL up_cycle_count: got count=%0d dir=%0b err=%0b, want 4 1 0",
               count_o, dir_o, err_o);
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b0, 1'b0);
    step_to(1'b0, 1'b1);
    n_checks++;
    if (count_o !== 8'd255 || dir_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_down_from_0: got count=%0d dir=%0b, want 255 0", count_o, dir_o);
    end
    step_to(1'b0, 1'b0);
    n_checks++;
    if (count_o !== 8'd0 || dir_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up_from_255: got count=%0d dir=%0b, want 0 1", count_o, dir_o);
    end
    step_to(1'b0, 1'b1);
    n_checks++;
    if (count_o !== 8'd255 || dir_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_down_again: got count=%0d dir=%0b, want 255 0", count_o, dir_o);
    end
  endtask

  // Continues from AB=01, count=255.
  task automatic test_glitch;
    int pulses;
    pulses = 0;
    quad_a = 1'b1;
    @(negedge clock);
    if (step_o === 1'b1) pulses++;
    quad_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (step_o === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL glitch_step: got %0d step pulses, want 0", pulses);
    end
    n_checks++;
    if (count_o !== 8'd255 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_state: got count=%0d err=%0b, want 255 0", count_o, err_o);
    end
  endtask

  // Continues from AB=01, count=255.
  task automatic test_error;
    int pulses;
    step_to(1'b0, 1'b0);
    step_to(1'b1, 1'b0);
    step_to(1'b1, 1'b1);
    step_to(1'b0, 1'b1);
    step_to(1'b0, 1'b0);
    n_checks++;
    if (count_o !== 8'd4) begin
      n_fail++;
      $display("FAIL error_setup: got count=%0d, want 4", count_o);
    end
    pulses = 0;
    quad_a = 1'b1;
    quad_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (step_o === 1'b1) pulses++;
    end
    n_checks++;
    if (err_o !== 1'b1 || count_o !== 8'd4 || dir_o !== 1'b1 || pulses !== 0) begin
      n_fail++;
      $display("FAIL error_flag: got err=%0b count=%0d dir=%0b pulses=%0d, want 1 4 1 0",
               err_o, count_o, dir_o, pulses);
    end
    repeat (10) @(negedge clock);
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL error_sticky: got err=%0b, want 1", err_o);
    end
    clear_i = 1'b1;
    @(negedge clock);
    clear_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b0 || count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL error_clear: got err=%0b count=%0d, want 0 0", err_o, count_o);
    end
  endtask

  // Continues from AB=11, count=0, dir=1.
  task automatic test_clear_on_step;
    step_to(1'b0, 1'b1);
    n_checks++;
    if (count_o !== 8'd1 || dir_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_setup: got count=%0d dir=%0b, want 1 1", count_o, dir_o);
    end
    // Down step 01->11 lands on the 5th edge; clear is held across that edge.
    quad_a = 1'b1;
    quad_b = 1'b1;
    repeat (4) @(negedge clock);
    clear_i = 1'b1;
    @(negedge clock);
    clear_i = 1'b0;
    n_checks++;
    if (count_o !== 8'd0 || step_o !== 1'b0 || dir_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_on_step: got count=%0d step=%0b dir=%0b, want 0 0 1",
               count_o, step_o, dir_o);
    end
    repeat (4) @(negedge clock);
    step_to(1'b0, 1'b1);
    n_checks++;
    if (count_o !== 8'd1 || dir_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_then_step: got count=%0d dir=%0b err=%0b, want 1 1 0",
               count_o, dir_o, err_o);
    end
  endtask

  // Reset asserted between clock edges must clear outputs immediately.
  task automatic test_async_reset;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (count_o !== 8'd0 || dir_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got count=%0d dir=%0b err=%0b, want 0 0 0",
               count_o, dir_o, err_o);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    quad_a  = 1'b0;
    quad_b  = 1'b0;
    clear_i = 1'b0;
    test_reset();
    test_up_cycle();
    test_wrap();
    test_glitch();
    test_error();
    test_clear_on_step();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that turns a two-channel incremental encoder (A/B, 90° phase offset) into an up/down position count. Both inputs are synchronised and glitch-filtered. Each legal Gray-code step produces one increment or decrement of a WIDTH-bit wrapping position counter. Illegal double-edge transitions are flagged. It sits at the pin boundary and feeds position, direction and step strobes to downstream control logic.

## Interface
- WIDTH, 8: position counter width in bits.
- FILTER_LEN, 2: consecutive cycles a synchronised channel must hold a new value before it is accepted (≥1).
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- quad_a  input  1  encoder channel A, asynchronous to clock.
- quad_b  input  1  encoder channel B, asynchronous to clock.
- clear_i  input  1  synchronous clear of count_o and err_o.
- count_o  output  WIDTH  position count.
- dir_o  output  1  direction of the last accepted step: 1 = up, 0 = down.
- step_o  output  1  one-cycle pulse when count_o has just changed.
- err_o  output  1  sticky illegal-transition flag.

## Operation
- Synchroniser: two flops per channel give sync_a and sync_b.
- Filter, per channel:
  - A stability counter runs while the sync value differs from the filtered value (filt_a / filt_b).
  - The filtered value takes the sync value on the edge that completes FILTER_LEN consecutive differing cycles.
  - Any cycle where sync equals filt resets the counter.
- State {filt_a, filt_b}. Up sequence: 00→10→11→01→00. Down sequence is the reverse.
- FSM:
  - INIT, entered on reset:
    - For FILTER_LEN+2 cycles, filt_a/filt_b load the sync values directly every cycle.
    - No counting and no error detection.
    - Then go to TRACK.
  - TRACK: compare the previous filtered state with the current one each cycle.
    - No change: nothing.
    - Legal up step: count_o +1, dir_o←1, step_o=1.
    - Legal down step: count_o −1, dir_o←0, step_o=1.
    - Both bits changed (00↔11, 10↔01): err_o←1, count_o and dir_o unchanged, step_o=0.
- Arithmetic is modulo 2^WIDTH:
  - Up from all-ones gives 0.
  - Down from 0 gives all-ones.
- clear_i (TRACK or INIT):
  - count_o←0 and err_o←0 on the next edge.
  - Takes priority over a same-cycle step or error: the step is dropped, step_o=0, dir_o unchanged.
  - The filtered state still updates, so tracking continues from the new position.
- err_o stays 1 until clear_i or reset.

## Timing
- Reset values: count_o=0, dir_o=0, step_o=0, err_o=0.
  - Sync flops, filt_a/filt_b and stability counters are 0.
  - FSM is in INIT.
- Reset asserted mid-operation: all of the above are applied immediately (asynchronous), and INIT is re-run after release.
- Latency: an input change first captured at edge 1 is reflected in count_o/dir_o/step_o at edge FILTER_LEN+3. With the default FILTER_LEN=2, that is edge 5.
- step_o is high for exactly one cycle per accepted step.
- Maximum accepted step rate: one step per FILTER_LEN+1 cycles per channel. Faster input activity may be filtered out or flagged as an error.
- Pulses shorter than FILTER_LEN cycles after synchronisation never reach the filtered value and cause no count.
- Both channels accepted on the same edge counts as an illegal transition (err_o←1).

## Test plan
- Reset release with quad_a=1, quad_b=1 held → after INIT, count_o=0, err_o=0, step_o never pulses.
- From AB=00, drive the up cycle 10,11,01,00, each held 8 cycles → count_o=4, dir_o=1, exactly four single-cycle step_o pulses, each FILTER_LEN+3 edges after its input change.
- Count up from 255 with one up step (WIDTH=8) → count_o=0. Then one down step → count_o=255, dir_o=0.
- Single-cycle glitch on quad_a (0→1→0) with FILTER_LEN=2 → count_o, step_o and err_o unchanged.
- From filtered 00, switch A and B to 11 on the same cycle → err_o=1 and stays 1, count_o unchanged. A later clear_i pulse → err_o=0, count_o=0.
- Assert clear_i on the cycle a step is accepted → count_o=0, step_o=0. The next legal up step gives count_o=1.
